// File: rtl/nand_nor_struct.sv
// rtl/nand_nor_struct.sv - registered bit-parallel NAND/NOR unit built from gate primitives
// Optional XOR/XNOR outputs are enabled by defining NAND_NOR_DERIVED_EN.
module nand_nor_struct #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             out_valid,
  output logic [WIDTH-1:0] Y_nand,
`ifdef NAND_NOR_DERIVED_EN
  output logic [WIDTH-1:0] Y_nor,
  output logic [WIDTH-1:0] Y_xor,
  output logic [WIDTH-1:0] Y_xnor
`else
  output logic [WIDTH-1:0] Y_nor
`endif
);

  wire [WIDTH-1:0] nand_w;
  wire [WIDTH-1:0] nor_w;

  logic             valid_q;
  logic [WIDTH-1:0] nand_q, nand_d;
  logic [WIDTH-1:0] nor_q, nor_d;

  // One gate cell per lane; lanes never interact.
  for (genvar i = 0; i < WIDTH; i++) begin : g_lane
    nand u_nand (nand_w[i], A[i], B[i]);
    nor  u_nor  (nor_w[i],  A[i], B[i]);
  end

  always_comb begin
    nand_d = nand_q;
    nor_d  = nor_q;
    if (in_valid) begin
      nand_d = nand_w;
      nor_d  = nor_w;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      nand_q  <= '0;
      nor_q   <= '0;
    end else begin
      valid_q <= in_valid;
      nand_q  <= nand_d;
      nor_q   <= nor_d;
    end
  end

  assign out_valid = valid_q;
  assign Y_nand    = nand_q;
  assign Y_nor     = nor_q;

`ifdef NAND_NOR_DERIVED_EN
  wire [WIDTH-1:0] xn1, xn2, xn3, xor_w;
  wire [WIDTH-1:0] xr1, xr2, xr3, xnor_w;

  logic [WIDTH-1:0] xor_q, xor_d;
  logic [WIDTH-1:0] xnor_q, xnor_d;

  // Classic four-NAND XOR and its dual, four-NOR XNOR.
  for (genvar i = 0; i < WIDTH; i++) begin : g_derived
    nand u_xn1 (xn1[i],   A[i],   B[i]);
    nand u_xn2 (xn2[i],   A[i],   xn1[i]);
    nand u_xn3 (xn3[i],   B[i],   xn1[i]);
    nand u_xn4 (xor_w[i], xn2[i], xn3[i]);
    nor  u_xr1 (xr1[i],    A[i],   B[i]);
    nor  u_xr2 (xr2[i],    A[i],   xr1[i]);
    nor  u_xr3 (xr3[i],    B[i],   xr1[i]);
    nor  u_xr4 (xnor_w[i], xr2[i], xr3[i]);
  end

  always_comb begin
    xor_d  = xor_q;
    xnor_d = xnor_q;
    if (in_valid) begin
      xor_d  = xor_w;
      xnor_d = xnor_w;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      xor_q  <= '0;
      xnor_q <= '0;
    end else begin
      xor_q  <= xor_d;
      xnor_q <= xnor_d;
    end
  end

  assign Y_xor  = xor_q;
  assign Y_xnor = xnor_q;
`endif

endmodule

// File: tb/tb_nand_nor_struct.sv
// tb/tb_nand_nor_struct.sv - self-checking bench for nand_nor_struct at WIDTH 1, 4 and 8
// Exercises XOR/XNOR outputs too when NAND_NOR_DERIVED_EN is defined.
module tb_nand_nor_struct;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  logic       iv1 = 1'b0, a1 = 1'b0, b1 = 1'b0;
  logic       ov1;
  logic       yn1, yr1;
  logic       iv4 = 1'b0;
  logic [3:0] a4 = '0, b4 = '0;
  logic       ov4;
  logic [3:0] yn4, yr4;
  logic       iv8 = 1'b0;
  logic [7:0] a8 = '0, b8 = '0;
  logic       ov8;
  logic [7:0] yn8, yr8;
`ifdef NAND_NOR_DERIVED_EN
  logic       yx1, yxn1;
  logic [3:0] yx4, yxn4;
  logic [7:0] yx8, yxn8;
`endif

  nand_nor_struct #(.WIDTH(1)) u_w1 (
    .clk(clk), .rst(rst), .in_valid(iv1), .A(a1), .B(b1),
    .out_valid(ov1), .Y_nand(yn1),
`ifdef NAND_NOR_DERIVED_EN
    .Y_nor(yr1), .Y_xor(yx1), .Y_xnor(yxn1)
`else
    .Y_nor(yr1)
`endif
  );

  nand_nor_struct #(.WIDTH(4)) u_w4 (
    .clk(clk), .rst(rst), .in_valid(iv4), .A(a4), .B(b4),
    .out_valid(ov4), .Y_nand(yn4),
`ifdef NAND_NOR_DERIVED_EN
    .Y_nor(yr4), .Y_xor(yx4), .Y_xnor(yxn4)
`else
    .Y_nor(yr4)
`endif
  );

  nand_nor_struct #(.WIDTH(8)) u_w8 (
    .clk(clk), .rst(rst), .in_valid(iv8), .A(a8), .B(b8),
    .out_valid(ov8), .Y_nand(yn8),
`ifdef NAND_NOR_DERIVED_EN
    .Y_nor(yr8), .Y_xor(yx8), .Y_xnor(yxn8)
`else
    .Y_nor(yr8)
`endif
  );

  task automatic test_reset();
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    total++;
    if ({ov1, ov4, ov8} !== 3'b000) begin
      bad++; $display("FAIL reset_valid got=%b exp=000", {ov1, ov4, ov8});
    end
    total++;
    if ({yn1, yr1, yn4, yr4, yn8, yr8} !== 26'd0) begin
      bad++; $display("FAIL reset_data got=%h exp=0", {yn1, yr1, yn4, yr4, yn8, yr8});
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_truth_w1();
    // Rows are {A,B,nand,nor} taken straight from the lane truth table.
    logic [3:0] rows [4] = '{4'b0011, 4'b0110, 4'b1010, 4'b1100};
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      iv1 = 1'b1; a1 = rows[i][3]; b1 = rows[i][2];
      @(posedge clk);
      #1;
      total++;
      if ({ov1, yn1, yr1} !== {1'b1, rows[i][1:0]}) begin
        bad++;
        $display("FAIL truth_w1 row=%0d got v/nand/nor=%b%b%b exp=1%b", i, ov1, yn1, yr1, rows[i][1:0]);
      end
    end
    @(negedge clk);
    iv1 = 1'b0;
  endtask

  task automatic test_w4_hold();
    @(negedge clk);
    iv4 = 1'b1; a4 = 4'b1100; b4 = 4'b1010;
    @(posedge clk);
    #1;
    total++;
    if ({ov4, yn4, yr4} !== {1'b1, 4'b0111, 4'b0001}) begin
      bad++; $display("FAIL w4_capture got v=%b nand=%b nor=%b exp v=1 nand=0111 nor=0001", ov4, yn4, yr4);
    end
`ifdef NAND_NOR_DERIVED_EN
    total++;
    if ({yx4, yxn4} !== {4'b0110, 4'b1001}) begin
      bad++; $display("FAIL w4_derived got xor=%b xnor=%b exp xor=0110 xnor=1001", yx4, yxn4);
    end
`endif
    @(negedge clk);
    iv4 = 1'b0; a4 = 4'b1111; b4 = 4'b1111;
    for (int k = 0; k < 2; k++) begin
      @(posedge clk);
      #1;
      total++;
      if ({ov4, yn4, yr4} !== {1'b0, 4'b0111, 4'b0001}) begin
        bad++; $display("FAIL w4_hold cyc=%0d got v=%b nand=%b nor=%b exp v=0 nand=0111 nor=0001", k, ov4, yn4, yr4);
      end
    end
  endtask

  task automatic test_reset_priority();
    @(negedge clk);
    rst = 1'b1; iv4 = 1'b1; a4 = 4'b0000; b4 = 4'b0000;
    @(posedge clk);
    #1;
    total++;
    if ({ov4, yn4, yr4} !== 9'd0) begin
      bad++; $display("FAIL rst_priority got v=%b nand=%b nor=%b exp all 0", ov4, yn4, yr4);
    end
`ifdef NAND_NOR_DERIVED_EN
    total++;
    if ({yx4, yxn4} !== 8'd0) begin
      bad++; $display("FAIL rst_derived got xor=%b xnor=%b exp 0", yx4, yxn4);
    end
`endif
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    total++;
    if ({ov4, yn4, yr4} !== {1'b1, 4'b1111, 4'b1111}) begin
      bad++; $display("FAIL post_rst_first got v=%b nand=%b nor=%b exp v=1 nand=1111 nor=1111", ov4, yn4, yr4);
    end
    @(negedge clk);
    iv4 = 1'b0;
  endtask

  task automatic test_random_w8();
    logic       m_valid = 1'b0;
    logic [7:0] m_nand = '0, m_nor = '0, m_xor = '0, m_xnor = '0;
    int         errs = 0;
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    for (int c = 0; c < 1000; c++) begin
      @(negedge clk);
      rst = ($urandom_range(0, 49) == 0);
      iv8 = ($urandom_range(0, 2) != 0);
      a8 = 8'($urandom);
      b8 = 8'($urandom);
      if (rst) begin
        m_valid = 1'b0; m_nand = '0; m_nor = '0; m_xor = '0; m_xnor = '0;
      end else begin
        m_valid = iv8;
        if (iv8) begin
          // Per lane: nand is 0 only when both are 1, nor is 1 only when both are 0.
          m_nand = 8'hFF - (a8 & b8);
          m_nor  = 8'hFF - (a8 | b8);
          m_xor  = (a8 | b8) - (a8 & b8);
          m_xnor = 8'hFF - m_xor;
        end
      end
      @(posedge clk);
      #1;
      total++;
      if ({ov8, yn8, yr8} !== {m_valid, m_nand, m_nor}) begin
        bad++;
        if (errs < 10)
          $display("FAIL rand_w8 cyc=%0d got v=%b nand=%h nor=%h exp v=%b nand=%h nor=%h",
                   c, ov8, yn8, yr8, m_valid, m_nand, m_nor);
        errs++;
      end
`ifdef NAND_NOR_DERIVED_EN
      total++;
      if ({yx8, yxn8} !== {m_xor, m_xnor}) begin
        bad++;
        if (errs < 10)
          $display("FAIL rand_w8_derived cyc=%0d got xor=%h xnor=%h exp xor=%h xnor=%h",
                   c, yx8, yxn8, m_xor, m_xnor);
        errs++;
      end
`endif
    end
    @(negedge clk);
    rst = 1'b0; iv8 = 1'b0;
  endtask

  initial begin
    test_reset();
    test_truth_w1();
    test_w4_hold();
    test_reset_priority();
    test_random_w8();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/nand_nor_struct.md
Name: nand_nor_struct

Overview:
- Registered, bit-parallel two-input NAND/NOR unit.
- Each output bit comes from its own gate-level (structural) NAND and NOR cell.
- Results are captured in an output register with a valid flag.
- It is the reusable logic-primitive slice under the team's gate-level exercise benches. It replaces separate bare nand/nor gate modules with one clocked, parameterised block.

Parameters:
- WIDTH, 1, number of independent bit lanes (legal range 1..64).

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  reset, synchronous, active-high.
- in_valid  input  1  qualifies A/B for capture this cycle.
- A  input  WIDTH  operand A, one bit per lane.
- B  input  WIDTH  operand B, one bit per lane.
- out_valid  output  1  Y outputs hold a fresh result.
- Y_nand  output  WIDTH  registered ~(A & B), per lane.
- Y_nor  output  WIDTH  registered ~(A | B), per lane.
- Y_xor  output  WIDTH  registered A ^ B. Present only with the optional feature.
- Y_xnor  output  WIDTH  registered ~(A ^ B). Present only with the optional feature.

Behaviour:
- Core logic is structural only.
  - Per lane, one nand primitive and one nor primitive, instantiated in a generate loop.
  - No behavioural operators in the logic core.
- Lanes are fully independent; there is no cross-lane logic.
- Latency is 1 cycle. If in_valid=1 at rising edge N, then after edge N:
  - Y_nand = ~(A&B) and Y_nor = ~(A|B), from A/B sampled at edge N.
  - out_valid = 1.
- If in_valid=0 at an edge:
  - out_valid = 0.
  - All Y outputs hold their previous values.
- Back-to-back valid inputs are accepted every cycle; there is no backpressure and no ready signal.
- Reset (rst=1 at an edge):
  - out_valid = 0, Y_nand = 0, Y_nor = 0 (and Y_xor = 0, Y_xnor = 0 when present).
  - Reset has priority over in_valid in the same cycle; the input presented that cycle is discarded.
  - Reset asserted mid-stream drops the in-flight result.
  - The first valid input after rst deasserts produces out_valid one cycle later.
- Before the first reset, output values are don't-care. The bench must reset first.
- Truth table per lane (A,B -> nand,nor): 00->1,1; 01->1,0; 10->1,0; 11->0,0.
- Y_nand and Y_nor are never both 0 when A≠B, and are both 1 only for A=B=0.

Optional Feature:
- Macro: NAND_NOR_DERIVED_EN.
- Defined:
  - Adds ports Y_xor and Y_xnor.
  - Y_xor per lane is built structurally from four 2-input NAND primitives (classic NAND-only XOR).
  - Y_xnor per lane is built structurally from four 2-input NOR primitives (classic NOR-only XNOR).
  - Both are registered with the same latency, valid, hold and reset rules as Y_nand/Y_nor.
- Undefined:
  - Ports and logic are absent.
  - Y_nand, Y_nor and out_valid are cycle-identical to the defined build.

Test Plan:
- WIDTH=1, reset 2 cycles, then in_valid=1 with (A,B) = 00, 01, 10, 11 on consecutive cycles, 10 time units apart per step.
  - Response, one cycle later each: Y_nand = 1,1,1,0; Y_nor = 1,0,0,0; out_valid = 1 on each.
- WIDTH=4, A=4'b1100, B=4'b1010, in_valid=1 -> next cycle Y_nand=4'b0111, Y_nor=4'b0001, out_valid=1.
- Hold: after the previous step, in_valid=0 with A=B=4'b1111 -> out_valid=0; Y_nand stays 4'b0111 and Y_nor stays 4'b0001.
- Reset priority: rst=1 and in_valid=1 with A=B=0 on the same edge -> Y_nand=0, Y_nor=0, out_valid=0. Next valid A=B=0 -> Y_nand=all 1s, Y_nor=all 1s.
- With NAND_NOR_DERIVED_EN, WIDTH=4, A=4'b1100, B=4'b1010 -> Y_xor=4'b0110, Y_xnor=4'b1001. Then reset -> both 0.
- Random regression, WIDTH=8, 1000 cycles, random in_valid/A/B -> every captured result matches the one-cycle-delayed ~(A&B) and ~(A|B); held values remain unchanged whenever in_valid=0.
